// File: rtl/pipe_sequencer_if.sv
// Pipeline sequencer control bundle.
//   master : sequencer side (takes hazard/event requests, drives pipeline controls)
//   slave  : pipeline side (raises requests, consumes controls)
// Ports carried:
//   s3_stall_req, redirect, redirect_pc, mdu_start, mdu_done, halt_req   (to sequencer)
//   freeze_front, freeze_s4a, bubble_s4a, bubble_s4b, flush_front,
//   pc_load, pc_load_value, mdu_kill, state, stall_timeout,
//   stall_cycles, redirect_count                                          (from sequencer)
interface pipe_sequencer_if #(
    parameter int unsigned WORD_W = 32
) ();
    localparam int unsigned STATE_W = 3;
    localparam int unsigned PERF_W  = 32;

    logic                s3_stall_req;
    logic                redirect;
    logic [WORD_W-1:0]   redirect_pc;
    logic                mdu_start;
    logic                mdu_done;
    logic                halt_req;

    logic                freeze_front;
    logic                freeze_s4a;
    logic                bubble_s4a;
    logic                bubble_s4b;
    logic                flush_front;
    logic                pc_load;
    logic [WORD_W-1:0]   pc_load_value;
    logic                mdu_kill;
    logic [STATE_W-1:0]  state;
    logic                stall_timeout;
    logic [PERF_W-1:0]   stall_cycles;
    logic [PERF_W-1:0]   redirect_count;

    modport master (
        input  s3_stall_req, redirect, redirect_pc, mdu_start, mdu_done, halt_req,
        output freeze_front, freeze_s4a, bubble_s4a, bubble_s4b, flush_front,
               pc_load, pc_load_value, mdu_kill, state, stall_timeout,
               stall_cycles, redirect_count
    );

    modport slave (
        output s3_stall_req, redirect, redirect_pc, mdu_start, mdu_done, halt_req,
        input  freeze_front, freeze_s4a, bubble_s4a, bubble_s4b, flush_front,
               pc_load, pc_load_value, mdu_kill, state, stall_timeout,
               stall_cycles, redirect_count
    );
endinterface

// File: rtl/pipe_sequencer.sv
// Pipeline sequencer: arbitrates redirects, multi-cycle ops, load-use stalls and
// halt requests into freeze/bubble/flush controls for a s1..s3 / s4a / s4b pipe.
// Control outputs are combinational from the registered state and the inputs.
// Ports:
//   clock : rising-edge clock
//   reset : asynchronous active-low reset
//   bus   : pipe_sequencer_if.master control bundle
// Parameters:
//   REDIRECT_PENALTY (1..15)    : flush_front cycles per redirect
//   STALL_LIMIT      (1..65535) : consecutive frozen cycles that trip the watchdog
// Build option:
//   PIPE_PERF_COUNTERS_EN : builds saturating stall_cycles / redirect_count counters;
//                           when undefined both ports read 0.
module pipe_sequencer #(
    parameter int unsigned REDIRECT_PENALTY = 2,
    parameter int unsigned STALL_LIMIT      = 255
) (
    input  logic             clock,
    input  logic             reset,
    pipe_sequencer_if.master bus
);
    localparam int unsigned PEN_W  = 4;
    localparam int unsigned WD_W   = 16;

    typedef enum logic [2:0] {
        RUN      = 3'd0,
        MDU_WAIT = 3'd1,
        REDIRECT = 3'd2,
        HALTED   = 3'd3
    } state_e;

    state_e             state_q, state_d;
    logic [PEN_W-1:0]   pen_q, pen_d;
    logic [WD_W-1:0]    wd_q, wd_inc;
    logic               timeout_q;
    logic               redirect_v;
    logic               wd_run;

    // A redirect seen while reset is held must not reach the pipeline.
    assign redirect_v = bus.redirect & reset;

    // State and penalty counter registers.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= RUN;
            pen_q   <= '0;
        end else begin
            state_q <= state_d;
            pen_q   <= pen_d;
        end
    end

    // Next state and control outputs; redirect pre-empts every other event.
    always_comb begin
        state_d            = state_q;
        pen_d              = pen_q;
        bus.freeze_front   = 1'b0;
        bus.freeze_s4a     = 1'b0;
        bus.bubble_s4a     = 1'b0;
        bus.bubble_s4b     = 1'b0;
        bus.flush_front    = 1'b0;
        bus.pc_load        = 1'b0;
        bus.pc_load_value  = '0;
        bus.mdu_kill       = 1'b0;

        if (redirect_v) begin
            bus.pc_load       = 1'b1;
            bus.pc_load_value = bus.redirect_pc;
            bus.flush_front   = 1'b1;
            bus.bubble_s4a    = 1'b1;
            bus.mdu_kill      = (state_q == MDU_WAIT);
            pen_d             = PEN_W'(REDIRECT_PENALTY - 1);
            state_d           = (REDIRECT_PENALTY > 1) ? REDIRECT : RUN;
        end else begin
            case (state_q)
                RUN: begin
                    if (bus.mdu_start) begin
                        state_d = MDU_WAIT;
                    end else if (bus.s3_stall_req) begin
                        bus.freeze_front = 1'b1;
                        bus.bubble_s4a   = 1'b1;
                    end else if (bus.halt_req) begin
                        state_d = HALTED;
                    end
                end
                MDU_WAIT: begin
                    if (bus.mdu_done) begin
                        state_d = RUN;
                    end else begin
                        bus.freeze_front = 1'b1;
                        bus.freeze_s4a   = 1'b1;
                        bus.bubble_s4b   = 1'b1;
                    end
                end
                REDIRECT: begin
                    // Leave on the edge where the counter reaches zero.
                    bus.flush_front = (pen_q != '0);
                    pen_d           = (pen_q != '0) ? pen_q - PEN_W'(1) : '0;
                    if (pen_q <= PEN_W'(1)) begin
                        state_d = RUN;
                    end
                    // Stall only matters once the flush is over.
                    if (bus.s3_stall_req && (pen_q == '0)) begin
                        bus.freeze_front = 1'b1;
                        bus.bubble_s4a   = 1'b1;
                    end
                end
                HALTED: begin
                    bus.freeze_front = 1'b1;
                    bus.bubble_s4a   = 1'b1;
                    if (!bus.halt_req) begin
                        state_d = RUN;
                    end
                end
                default: state_d = RUN;
            endcase
        end
    end

    assign bus.state = state_q;

    // Watchdog: counts consecutive frozen cycles, ignoring a deliberate halt.
    assign wd_run = bus.freeze_front && (state_q != HALTED);
    assign wd_inc = (wd_q == '1) ? wd_q : wd_q + WD_W'(1);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wd_q      <= '0;
            timeout_q <= 1'b0;
        end else begin
            if (wd_run) begin
                wd_q <= wd_inc;
            end else if (!bus.freeze_front) begin
                wd_q <= '0;
            end
            if (wd_run && (wd_inc >= WD_W'(STALL_LIMIT))) begin
                timeout_q <= 1'b1;
            end
        end
    end

    assign bus.stall_timeout = timeout_q;

`ifdef PIPE_PERF_COUNTERS_EN
    localparam int unsigned PERF_W = 32;

    logic [PERF_W-1:0] stall_cnt_q;
    logic [PERF_W-1:0] redir_cnt_q;

    // Saturating performance counters.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            stall_cnt_q <= '0;
            redir_cnt_q <= '0;
        end else begin
            if (bus.freeze_front && (stall_cnt_q != '1)) begin
                stall_cnt_q <= stall_cnt_q + PERF_W'(1);
            end
            if (redirect_v && (redir_cnt_q != '1)) begin
                redir_cnt_q <= redir_cnt_q + PERF_W'(1);
            end
        end
    end

    assign bus.stall_cycles   = stall_cnt_q;
    assign bus.redirect_count = redir_cnt_q;
`else
    assign bus.stall_cycles   = '0;
    assign bus.redirect_count = '0;
`endif

endmodule

// File: tb/tb_pipe_sequencer.sv
// Directed bench for pipe_sequencer (REDIRECT_PENALTY=3, STALL_LIMIT=4).
// Inputs change just after the falling edge; outputs are sampled 1 time unit later.
// Per-cycle stimulus code: {s3_stall_req, redirect, mdu_start, mdu_done, halt_req}.
// Per-cycle expectation:   {state[2:0], freeze_front, freeze_s4a, bubble_s4a, bubble_s4b,
//                           flush_front, pc_load, mdu_kill, stall_timeout}.
module tb_pipe_sequencer;
    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

`ifdef PIPE_PERF_COUNTERS_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    pipe_sequencer_if #(.WORD_W(32)) bus ();

    pipe_sequencer #(
        .REDIRECT_PENALTY(3),
        .STALL_LIMIT     (4)
    ) dut (
        .clock(clk),
        .reset(rst_n),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [10:0] obs();
        return {bus.state, bus.freeze_front, bus.freeze_s4a, bus.bubble_s4a, bus.bubble_s4b,
                bus.flush_front, bus.pc_load, bus.mdu_kill, bus.stall_timeout};
    endfunction

    task automatic drive(input logic [4:0] s);
        @(negedge clk);
        bus.s3_stall_req = s[4];
        bus.redirect     = s[3];
        bus.mdu_start    = s[2];
        bus.mdu_done     = s[1];
        bus.halt_req     = s[0];
        #1;
    endtask

    task automatic apply_reset();
        @(negedge clk);
        bus.s3_stall_req = 1'b0;
        bus.redirect     = 1'b0;
        bus.redirect_pc  = '0;
        bus.mdu_start    = 1'b0;
        bus.mdu_done     = 1'b0;
        bus.halt_req     = 1'b0;
        rst_n = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        logic [10:0] o;
        @(negedge clk);
        rst_n = 1'b0;
        bus.s3_stall_req = 1'b1;
        bus.redirect     = 1'b1;
        bus.redirect_pc  = 32'h55;
        bus.mdu_start    = 1'b0;
        bus.mdu_done     = 1'b0;
        bus.halt_req     = 1'b0;
        #1;
        o = obs();
        checks++;
        if (o !== 11'h0A0) begin
            $display("FAIL reset_inputs: got %h expected %h", o, 11'h0A0); errors++;
        end
        checks++;
        if (bus.pc_load_value !== 32'h0) begin
            $display("FAIL reset_pcval: got %h expected 0", bus.pc_load_value); errors++;
        end
        @(negedge clk);
        #1;
        checks++;
        if ({bus.stall_cycles, bus.redirect_count} !== 64'h0) begin
            $display("FAIL reset_counters: got %h/%h expected 0/0", bus.stall_cycles, bus.redirect_count);
            errors++;
        end
        bus.s3_stall_req = 1'b0;
        bus.redirect     = 1'b0;
        bus.redirect_pc  = '0;
        rst_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            drive(5'b00000);
            o = obs();
            checks++;
            if ({o, bus.pc_load_value, bus.stall_cycles, bus.redirect_count} !== 107'h0) begin
                $display("FAIL reset_idle cyc %0d: got %h pc %h sc %0d rc %0d expected all 0",
                         i, o, bus.pc_load_value, bus.stall_cycles, bus.redirect_count);
                errors++;
            end
        end
    endtask

    task automatic test_stall();
        logic [4:0]  st [4] = '{5'b10000, 5'b10000, 5'b10000, 5'b00000};
        logic [10:0] ex [4] = '{11'h0A0, 11'h0A0, 11'h0A0, 11'h000};
        logic [10:0] o;
        apply_reset();
        for (int i = 0; i < 4; i++) begin
            drive(st[i]);
            o = obs();
            checks++;
            if (o !== ex[i]) begin
                $display("FAIL stall cyc %0d: got %h expected %h", i, o, ex[i]); errors++;
            end
        end
        checks++;
        if (bus.stall_cycles !== (PERF ? 32'd3 : 32'd0)) begin
            $display("FAIL stall_cycles: got %0d expected %0d", bus.stall_cycles, PERF ? 3 : 0);
            errors++;
        end
    endtask

    task automatic test_redirect();
        logic [4:0]  st [6] = '{5'b01000, 5'b00000, 5'b10000, 5'b00000, 5'b10000, 5'b00000};
        logic [10:0] ex [6] = '{11'h02C, 11'h208, 11'h208, 11'h000, 11'h0A0, 11'h000};
        logic [10:0] o;
        apply_reset();
        bus.redirect_pc = 32'h0000_0100;
        for (int i = 0; i < 6; i++) begin
            drive(st[i]);
            o = obs();
            checks++;
            if (o !== ex[i]) begin
                $display("FAIL redirect cyc %0d: got %h expected %h", i, o, ex[i]); errors++;
            end
            if (i == 0) begin
                checks++;
                if (bus.pc_load_value !== 32'h0000_0100) begin
                    $display("FAIL redirect_pcval: got %h expected 00000100", bus.pc_load_value);
                    errors++;
                end
            end
        end
        checks++;
        if (bus.redirect_count !== (PERF ? 32'd1 : 32'd0)) begin
            $display("FAIL redirect_count: got %0d expected %0d", bus.redirect_count, PERF ? 1 : 0);
            errors++;
        end
    endtask

    task automatic test_back_to_back();
        logic [4:0]  st [5] = '{5'b01000, 5'b01000, 5'b00000, 5'b00000, 5'b00000};
        logic [10:0] ex [5] = '{11'h02C, 11'h22C, 11'h208, 11'h208, 11'h000};
        logic [10:0] o;
        apply_reset();
        bus.redirect_pc = 32'h0000_0200;
        for (int i = 0; i < 5; i++) begin
            drive(st[i]);
            o = obs();
            checks++;
            if (o !== ex[i]) begin
                $display("FAIL back_to_back cyc %0d: got %h expected %h", i, o, ex[i]); errors++;
            end
        end
        checks++;
        if (bus.redirect_count !== (PERF ? 32'd2 : 32'd0)) begin
            $display("FAIL b2b_redirect_count: got %0d expected %0d", bus.redirect_count, PERF ? 2 : 0);
            errors++;
        end
    endtask

    task automatic test_mdu();
        logic [4:0]  st [7] = '{5'b10100, 5'b00000, 5'b00000, 5'b00000, 5'b00000, 5'b00010, 5'b00000};
        logic [10:0] ex [7] = '{11'h000, 11'h1D0, 11'h1D0, 11'h1D0, 11'h1D0, 11'h101, 11'h001};
        logic [10:0] o;
        apply_reset();
        for (int i = 0; i < 7; i++) begin
            drive(st[i]);
            o = obs();
            checks++;
            if (o !== ex[i]) begin
                $display("FAIL mdu cyc %0d: got %h expected %h", i, o, ex[i]); errors++;
            end
        end
        checks++;
        if (bus.stall_cycles !== (PERF ? 32'd4 : 32'd0)) begin
            $display("FAIL mdu_stall_cycles: got %0d expected %0d", bus.stall_cycles, PERF ? 4 : 0);
            errors++;
        end
    endtask

    task automatic test_mdu_kill();
        logic [4:0]  st [6] = '{5'b00100, 5'b00000, 5'b01010, 5'b00000, 5'b00000, 5'b00000};
        logic [10:0] ex [6] = '{11'h000, 11'h1D0, 11'h12E, 11'h208, 11'h208, 11'h000};
        logic [10:0] o;
        apply_reset();
        bus.redirect_pc = 32'h0000_0300;
        for (int i = 0; i < 6; i++) begin
            drive(st[i]);
            o = obs();
            checks++;
            if (o !== ex[i]) begin
                $display("FAIL mdu_kill cyc %0d: got %h expected %h", i, o, ex[i]); errors++;
            end
            if (i == 2) begin
                checks++;
                if (bus.pc_load_value !== 32'h0000_0300) begin
                    $display("FAIL mdu_kill_pcval: got %h expected 00000300", bus.pc_load_value);
                    errors++;
                end
            end
        end
    endtask

    task automatic test_halt();
        logic [4:0]  st [15] = '{5'b10001, 5'b00001, 5'b00001, 5'b00001, 5'b00001, 5'b00001,
                                 5'b00001, 5'b00001, 5'b00000, 5'b00000, 5'b00001, 5'b01001,
                                 5'b00000, 5'b00000, 5'b00000};
        logic [10:0] ex [15] = '{11'h0A0, 11'h000, 11'h3A0, 11'h3A0, 11'h3A0, 11'h3A0,
                                 11'h3A0, 11'h3A0, 11'h3A0, 11'h000, 11'h000, 11'h32C,
                                 11'h208, 11'h208, 11'h000};
        logic [10:0] o;
        apply_reset();
        bus.redirect_pc = 32'h0000_0400;
        for (int i = 0; i < 15; i++) begin
            drive(st[i]);
            o = obs();
            checks++;
            if (o !== ex[i]) begin
                $display("FAIL halt cyc %0d: got %h expected %h", i, o, ex[i]); errors++;
            end
        end
    endtask

    task automatic test_watchdog();
        logic [4:0]  st [9] = '{5'b10000, 5'b10000, 5'b10000, 5'b10000, 5'b10000, 5'b10000,
                                5'b00000, 5'b00000, 5'b00000};
        logic [10:0] ex [9] = '{11'h0A0, 11'h0A0, 11'h0A0, 11'h0A0, 11'h0A1, 11'h0A1,
                                11'h001, 11'h001, 11'h001};
        logic [10:0] o;
        apply_reset();
        for (int i = 0; i < 9; i++) begin
            drive(st[i]);
            o = obs();
            checks++;
            if (o !== ex[i]) begin
                $display("FAIL watchdog cyc %0d: got %h expected %h", i, o, ex[i]); errors++;
            end
        end
        checks++;
        if (bus.stall_cycles !== (PERF ? 32'd6 : 32'd0)) begin
            $display("FAIL wd_stall_cycles: got %0d expected %0d", bus.stall_cycles, PERF ? 6 : 0);
            errors++;
        end
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        o = obs();
        checks++;
        if (o !== 11'h000) begin
            $display("FAIL watchdog_reset: got %h expected %h", o, 11'h000); errors++;
        end
    endtask

    task automatic test_reset_abort();
        logic [10:0] o;
        apply_reset();
        drive(5'b00100);
        drive(5'b00000);
        o = obs();
        checks++;
        if (o !== 11'h1D0) begin
            $display("FAIL abort_mdu_wait: got %h expected %h", o, 11'h1D0); errors++;
        end
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        o = obs();
        checks++;
        if (o !== 11'h000) begin
            $display("FAIL abort_mdu_reset: got %h expected %h", o, 11'h000); errors++;
        end
        apply_reset();
        bus.redirect_pc = 32'h0000_0500;
        drive(5'b01000);
        drive(5'b00000);
        o = obs();
        checks++;
        if (o !== 11'h208) begin
            $display("FAIL abort_redirect_wait: got %h expected %h", o, 11'h208); errors++;
        end
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        o = obs();
        checks++;
        if (o !== 11'h000) begin
            $display("FAIL abort_redirect_reset: got %h expected %h", o, 11'h000); errors++;
        end
        @(negedge clk);
        rst_n = 1'b1;
        drive(5'b00000);
        o = obs();
        checks++;
        if (o !== 11'h000) begin
            $display("FAIL abort_after_release: got %h expected %h", o, 11'h000); errors++;
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst_n  = 1'b0;
        bus.s3_stall_req = 1'b0;
        bus.redirect     = 1'b0;
        bus.redirect_pc  = '0;
        bus.mdu_start    = 1'b0;
        bus.mdu_done     = 1'b0;
        bus.halt_req     = 1'b0;
        test_reset();
        test_stall();
        test_redirect();
        test_back_to_back();
        test_mdu();
        test_mdu_kill();
        test_halt();
        test_watchdog();
        test_reset_abort();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
